apb_master: RTL and testbench
=============================

Name: apb_master

Overview:
- APB requester (bridge) that converts a simple valid/ready command interface into APB4 SETUP/ACCESS transfers. It drives the APB slave ports of the peripheral memory block and returns read data and an error status on a response channel.
- Sits between an internal controller or UVM-driven command port and any APB completer with the same ADDR_WIDTH/DATA_WIDTH.
- Adds a wait-state timeout so a hung completer cannot stall the requester forever.

Parameters:
- ADDR_WIDTH, 8, APB address width.
- DATA_WIDTH, 32, APB data width; must be a multiple of 8.
- TIMEOUT, 16, maximum number of ACCESS cycles with PREADY low before abort. 0 disables the timeout.

Ports:
- PCLK in 1: APB clock.
- PRESETn in 1: asynchronous, active-low reset.
- cmd_valid in 1: command request.
- cmd_ready out 1: command accepted when cmd_valid && cmd_ready.
- cmd_write in 1: 1 = write, 0 = read.
- cmd_addr in ADDR_WIDTH: transfer address.
- cmd_wdata in DATA_WIDTH: write data.
- cmd_strb in DATA_WIDTH/8: byte strobes; ignored for reads.
- rsp_valid out 1: response available.
- rsp_ready in 1: response consumed when rsp_valid && rsp_ready.
- rsp_rdata out DATA_WIDTH: read data; 0 for writes and on timeout.
- rsp_err out 1: PSLVERR seen, or timeout.
- rsp_timeout out 1: transfer aborted by timeout.
- PSEL out 1: APB select.
- PENABLE out 1: APB enable.
- PWRITE out 1: APB direction.
- PADDR out ADDR_WIDTH: APB address.
- PWDATA out DATA_WIDTH: APB write data.
- PSTRB out DATA_WIDTH/8: APB strobes.
- PRDATA in DATA_WIDTH: completer read data.
- PREADY in 1: completer ready.
- PSLVERR in 1: completer error.

Behaviour:
- All outputs are registered except cmd_ready, which is (state==IDLE).
- Reset, asynchronous, any state:
  - state=IDLE.
  - PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB = 0.
  - rsp_valid, rsp_rdata, rsp_err, rsp_timeout = 0.
  - Wait counter = 0.
  - A transfer in progress is dropped with no response.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready=1.
  - On acceptance, latch PADDR=cmd_addr and PWRITE=cmd_write.
  - For writes: PWDATA=cmd_wdata, PSTRB=cmd_strb. For reads: PWDATA=0, PSTRB=0.
  - Set PSEL=1 and go to SETUP.
- SETUP (exactly 1 cycle): PSEL=1, PENABLE=0. Next cycle PENABLE=1, clear the wait counter, go to ACCESS.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - PADDR, PWRITE, PWDATA and PSTRB stay stable from SETUP until the transfer ends.
  - PREADY=1 sampled on a PCLK edge:
    - Completes the transfer: PSEL=0, PENABLE=0.
    - rsp_rdata = PWRITE ? 0 : PRDATA.
    - rsp_err=PSLVERR, rsp_timeout=0, rsp_valid=1.
    - Go to RESP.
  - PREADY=0: increment the wait counter.
    - If TIMEOUT!=0 and the counter reaches TIMEOUT, i.e. the TIMEOUT-th consecutive ACCESS cycle has PREADY=0, abort.
    - Abort: PSEL=0, PENABLE=0, rsp_valid=1, rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
    - PREADY=1 on that same edge wins: normal completion, no timeout.
  - PSLVERR and PRDATA are ignored whenever PREADY=0.
- RESP:
  - rsp_valid and the response fields are held until rsp_ready=1.
  - On handshake: rsp_valid=0, go to IDLE.
  - cmd_ready=0 throughout; no new command is accepted until IDLE.
- Throughput: minimum 4 cycles per transfer (accept, SETUP, ACCESS, RESP) with zero wait states and rsp_ready tied high. There is no back-to-back ACCESS; PSEL deasserts between transfers.
- The counter is sized $clog2(TIMEOUT+1)+1 bits and never wraps; it is cleared on entry to ACCESS.
- cmd_* inputs change freely outside the accept cycle; only the values at acceptance are used.

Test Plan:
- Write, no wait states:
  - Stimulus: cmd addr=0x10, wdata=0xDEADBEEF, strb=4'hF; PREADY=1 in ACCESS.
  - Required: SETUP cycle shows PSEL=1, PENABLE=0, PADDR=0x10, PWRITE=1, PSTRB=F.
  - Next cycle PENABLE=1, then rsp_valid=1, rsp_err=0, rsp_rdata=0.
- Read, 4 wait states:
  - Stimulus: addr=0x10; PREADY low for 4 ACCESS cycles then high, PRDATA=0xDEADBEEF.
  - Required: PADDR, PWRITE=0 and PSTRB=0 stable for 5 ACCESS cycles; rsp_rdata=0xDEADBEEF, rsp_err=0.
- Slave error:
  - Stimulus: write to addr=0xC0; completer returns PREADY=1, PSLVERR=1.
  - Required: rsp_err=1, rsp_timeout=0; PSEL=0 the cycle after completion.
- Timeout:
  - Stimulus: TIMEOUT=16, PREADY held 0.
  - Required: after the 16th ACCESS cycle PSEL=0, PENABLE=0, rsp_err=1, rsp_timeout=1, rsp_rdata=0.
  - Repeat with PREADY=1 on the 16th cycle: normal completion, rsp_timeout=0.
- Response backpressure:
  - Stimulus: rsp_ready=0 for 5 cycles, cmd_valid held 1.
  - Required: rsp fields held constant, cmd_ready=0, no second SETUP until 1 cycle after the rsp handshake.
- Reset mid-ACCESS:
  - Stimulus: assert PRESETn=0 during the 2nd wait state.
  - Required: all outputs 0 immediately (asynchronous), cmd_ready=1 after release, no rsp_valid; the next command runs normally.

Source files
------------

// File: rtl/apb_master.sv
// apb_master: turns a valid/ready command into one APB4 SETUP/ACCESS transfer and returns a response.
// Latency: accept, SETUP, ACCESS (1 + wait states, capped at TIMEOUT), RESP; at least 4 cycles per transfer.
// Backpressure: cmd_ready only in IDLE; the response is held in RESP until rsp_ready, with no new command taken meanwhile.
module apb_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // command channel
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  // response channel
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  // APB requester side
  output logic                    PSEL,
  output logic                    PENABLE,
  output logic                    PWRITE,
  output logic [ADDR_WIDTH-1:0]   PADDR,
  output logic [DATA_WIDTH-1:0]   PWDATA,
  output logic [DATA_WIDTH/8-1:0] PSTRB,
  input  logic [DATA_WIDTH-1:0]   PRDATA,
  input  logic                    PREADY,
  input  logic                    PSLVERR
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;
  // One spare bit over what TIMEOUT needs, so the count can never wrap back to zero.
  localparam int CNT_WIDTH  = $clog2(TIMEOUT + 1) + 1;
  // Count value held during the last permitted wait cycle; the abort fires when it would step to TIMEOUT.
  localparam int TO_LAST    = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } state_t;

  state_t                  r_state;
  logic                    r_psel;
  logic                    r_penable;
  logic                    r_pwrite;
  logic [ADDR_WIDTH-1:0]   r_paddr;
  logic [DATA_WIDTH-1:0]   r_pwdata;
  logic [STRB_WIDTH-1:0]   r_pstrb;
  logic                    r_rsp_valid;
  logic [DATA_WIDTH-1:0]   r_rsp_rdata;
  logic                    r_rsp_err;
  logic                    r_rsp_timeout;
  logic [CNT_WIDTH-1:0]    r_wait_cnt;

  logic                    w_timeout_hit;
  logic                    w_cnt_sat;

  // Abort when this wait cycle is the TIMEOUT-th consecutive one with PREADY low.
  assign w_timeout_hit = (TIMEOUT != 0) && (r_wait_cnt == CNT_WIDTH'(TO_LAST));
  // Only reachable with the timeout disabled; keeps the counter pinned instead of wrapping.
  assign w_cnt_sat     = (r_wait_cnt == {CNT_WIDTH{1'b1}});

  assign cmd_ready   = (r_state == ST_IDLE);
  assign PSEL        = r_psel;
  assign PENABLE     = r_penable;
  assign PWRITE      = r_pwrite;
  assign PADDR       = r_paddr;
  assign PWDATA      = r_pwdata;
  assign PSTRB       = r_pstrb;
  assign rsp_valid   = r_rsp_valid;
  assign rsp_rdata   = r_rsp_rdata;
  assign rsp_err     = r_rsp_err;
  assign rsp_timeout = r_rsp_timeout;

  // Transfer sequencer: owns every registered APB and response output plus the wait counter.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_state       <= ST_IDLE;
      r_psel        <= 1'b0;
      r_penable     <= 1'b0;
      r_pwrite      <= 1'b0;
      r_paddr       <= '0;
      r_pwdata      <= '0;
      r_pstrb       <= '0;
      r_rsp_valid   <= 1'b0;
      r_rsp_rdata   <= '0;
      r_rsp_err     <= 1'b0;
      r_rsp_timeout <= 1'b0;
      r_wait_cnt    <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            // Reads drive zero data/strobes so the bus never carries stale write values.
            r_paddr  <= cmd_addr;
            r_pwrite <= cmd_write;
            r_pwdata <= cmd_write ? cmd_wdata : '0;
            r_pstrb  <= cmd_write ? cmd_strb  : '0;
            r_psel   <= 1'b1;
            r_state  <= ST_SETUP;
          end
        end

        ST_SETUP: begin
          r_penable  <= 1'b1;
          r_wait_cnt <= '0;
          r_state    <= ST_ACCESS;
        end

        ST_ACCESS: begin
          if (PREADY) begin
            // Completion beats a timeout landing on the same edge.
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_rdata   <= r_pwrite ? '0 : PRDATA;
            r_rsp_err     <= PSLVERR;
            r_rsp_timeout <= 1'b0;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (w_timeout_hit) begin
            r_wait_cnt    <= r_wait_cnt + 1'b1;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b1;
            r_rsp_timeout <= 1'b1;
            r_rsp_valid   <= 1'b1;
            r_state       <= ST_RESP;
          end else if (!w_cnt_sat) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end

        ST_RESP: begin
          // Response fields stay put after the handshake; only the valid flag drops.
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end

        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: table-driven and randomized checks of apb_master against a transaction-level model.
// Inputs are driven and outputs sampled on the falling edge; the DUT acts on the rising edge.
// The bench plays the APB completer, inserting a per-transfer number of wait states and response stalls.
`timescale 1ns/1ps
module tb_apb_master;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int TO = 16;

  logic          PCLK = 1'b0;
  logic          PRESETn = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_write = 1'b0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_wdata = '0;
  logic [SW-1:0] cmd_strb = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b0;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  logic          PSEL;
  logic          PENABLE;
  logic          PWRITE;
  logic [AW-1:0] PADDR;
  logic [DW-1:0] PWDATA;
  logic [SW-1:0] PSTRB;
  logic [DW-1:0] PRDATA = '0;
  logic          PREADY = 1'b0;
  logic          PSLVERR = 1'b0;

  apb_master #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PSTRB(PSTRB), .PRDATA(PRDATA), .PREADY(PREADY),
    .PSLVERR(PSLVERR)
  );

  always #5 PCLK = ~PCLK;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit            write;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    int            nwait;      // ACCESS cycles with PREADY low before the completer answers
    logic [DW-1:0] prdata;
    bit            slverr;
    int            rsp_delay;  // cycles of rsp_ready low before the response is taken
    logic [DW-1:0] exp_rdata;
    bit            exp_err;
    bit            exp_to;
    int            exp_access; // ACCESS cycles the transfer occupies
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] wd,
                              input logic [SW-1:0] st, input int nw, input logic [DW-1:0] rd,
                              input bit se, input int dly, input logic [DW-1:0] e_rd,
                              input bit e_err, input bit e_to, input int e_acc);
    vec_t v;
    v.write = wr; v.addr = a; v.wdata = wd; v.strb = st; v.nwait = nw; v.prdata = rd;
    v.slverr = se; v.rsp_delay = dly; v.exp_rdata = e_rd; v.exp_err = e_err;
    v.exp_to = e_to; v.exp_access = e_acc;
    return v;
  endfunction

  // Transaction-level expectation: a transfer either finishes on the completer's
  // first ready cycle or is cut off after TO low cycles, whichever comes first.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    bit   timed_out;
    r = v;
    timed_out    = (TO != 0) && (v.nwait >= TO);
    r.exp_to     = timed_out;
    r.exp_err    = timed_out || v.slverr;
    r.exp_rdata  = (v.write || timed_out) ? '0 : v.prdata;
    r.exp_access = timed_out ? TO : v.nwait + 1;
    return r;
  endfunction

  task automatic check_quiet(input string tag);
    check({tag, ".apb"}, 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}), 64'd0);
    check({tag, ".rsp"}, 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata}), 64'd0);
    check({tag, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
  endtask

  // Runs one complete transfer; entered and left just after a falling edge with the DUT idle.
  task automatic run_xfer(input vec_t v, input string tag);
    logic [DW-1:0] exp_pwdata;
    logic [SW-1:0] exp_pstrb;
    int            n;
    bit            done;
    exp_pwdata = v.write ? v.wdata : '0;
    exp_pstrb  = v.write ? v.strb  : '0;
    check({tag, ".idle_ready"}, 64'(cmd_ready), 64'd1);
    cmd_valid = 1'b1; cmd_write = v.write; cmd_addr = v.addr;
    cmd_wdata = v.wdata; cmd_strb = v.strb;
    PREADY = 1'b0; PSLVERR = 1'b0; PRDATA = $urandom;
    @(negedge PCLK);
    // Command inputs are free to change once accepted.
    cmd_valid = 1'b0; cmd_write = 1'($urandom); cmd_addr = AW'($urandom);
    cmd_wdata = $urandom; cmd_strb = SW'($urandom);
    check({tag, ".setup"}, 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB}),
          64'({1'b1, 1'b0, v.write, v.addr, exp_pwdata, exp_pstrb}));
    check({tag, ".setup_cmd_ready"}, 64'(cmd_ready), 64'd0);
    @(negedge PCLK);
    n = 0; done = 1'b0;
    while (!done && n < 64) begin
      n++;
      check({tag, ".access"}, 64'({PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, cmd_ready}),
            64'({1'b1, 1'b1, v.write, v.addr, exp_pwdata, exp_pstrb, 1'b0}));
      PREADY  = (n > v.nwait);
      PSLVERR = PREADY ? v.slverr : 1'($urandom);
      PRDATA  = PREADY ? v.prdata : $urandom;
      @(negedge PCLK);
      done = rsp_valid;
    end
    check({tag, ".rsp_seen"}, 64'(done), 64'd1);
    PREADY = 1'b0; PSLVERR = 1'($urandom); PRDATA = $urandom;
    check({tag, ".released"}, 64'({PSEL, PENABLE, cmd_ready}), 64'd0);
    check({tag, ".access_cycles"}, 64'(n), 64'(v.exp_access));
    check({tag, ".rdata"}, 64'(rsp_rdata), 64'(v.exp_rdata));
    check({tag, ".err"}, 64'(rsp_err), 64'(v.exp_err));
    check({tag, ".timeout"}, 64'(rsp_timeout), 64'(v.exp_to));
    // A pending command during the stall must not start a new transfer.
    cmd_valid = 1'b1; rsp_ready = 1'b0;
    for (int i = 0; i < v.rsp_delay; i++) begin
      @(negedge PCLK);
      check({tag, ".hold"}, 64'({rsp_valid, rsp_err, rsp_timeout, rsp_rdata, cmd_ready, PSEL}),
            64'({1'b1, v.exp_err, v.exp_to, v.exp_rdata, 1'b0, 1'b0}));
    end
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0; cmd_valid = 1'b0;
    check({tag, ".handshake"}, 64'({rsp_valid, PSEL, cmd_ready}), 64'b001);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got no end, expected end before 1ms");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[8];
    vec_t rv;

    tbl[0] = mk(1, 8'h10, 32'hDEADBEEF, 4'hF,   0, 32'h12345678, 0, 0, 32'h0,        0, 0,  1);
    tbl[1] = mk(0, 8'h10, 32'hCAFEF00D, 4'hF,   4, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF, 0, 0,  5);
    tbl[2] = mk(1, 8'hC0, 32'h55AA55AA, 4'h3,   0, 32'h87654321, 1, 0, 32'h0,        1, 0,  1);
    tbl[3] = mk(0, 8'h20, 32'h11111111, 4'hF, 100, 32'hFFFFFFFF, 0, 1, 32'h0,        1, 1, 16);
    tbl[4] = mk(0, 8'h24, 32'h22222222, 4'h1,  15, 32'hA5A5A5A5, 0, 0, 32'hA5A5A5A5, 0, 0, 16);
    tbl[5] = mk(0, 8'h44, 32'h33333333, 4'h0,   2, 32'h0BADF00D, 1, 2, 32'h0BADF00D, 1, 0,  3);
    tbl[6] = mk(1, 8'hFF, 32'h01020304, 4'h5,   1, 32'h99999999, 0, 5, 32'h0,        0, 0,  2);
    tbl[7] = mk(1, 8'h80, 32'h44444444, 4'hA,  20, 32'h77777777, 1, 0, 32'h0,        1, 1, 16);

    // Reset state
    PRESETn = 1'b0;
    repeat (2) @(negedge PCLK);
    check_quiet("reset");
    PRESETn = 1'b1;
    @(negedge PCLK);
    check_quiet("post_reset");

    // Directed vectors, back to back
    for (int i = 0; i < 8; i++) begin
      run_xfer(tbl[i], $sformatf("vec%0d", i));
    end

    // Reset during the second wait state of a read
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h33; cmd_wdata = 32'h5A5A5A5A; cmd_strb = 4'hF;
    PREADY = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    @(negedge PCLK);
    check("rst_mid.in_access", 64'({PSEL, PENABLE, PADDR}), 64'({1'b1, 1'b1, 8'h33}));
    #2 PRESETn = 1'b0;
    #1 check_quiet("rst_mid.async");
    @(negedge PCLK);
    PRESETn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge PCLK);
      check("rst_mid.no_rsp", 64'({rsp_valid, PSEL, PENABLE, cmd_ready}), 64'b0001);
    end
    run_xfer(tbl[0], "rst_mid.next");

    // Randomized transfers against the model
    for (int i = 0; i < 40; i++) begin
      rv.write     = 1'($urandom);
      rv.addr      = AW'($urandom);
      rv.wdata     = $urandom;
      rv.strb      = SW'($urandom);
      rv.nwait     = $urandom_range(0, 20);
      rv.prdata    = $urandom;
      rv.slverr    = 1'($urandom);
      rv.rsp_delay = $urandom_range(0, 3);
      rv = model(rv);
      run_xfer(rv, $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
